// File: rtl/ball_step_sequencer.sv
// Per-ball physics step initiator: owns the ball state register file and,
// once per frame, streams each active ball through the external step unit,
// writing the returned position/velocity back verbatim.
module ball_step_sequencer #(
    parameter int WIDTH      = 32,
    parameter int FRAC_WIDTH = 30,
    parameter int NUM_BALLS  = 16,
    parameter int IDX_W      = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W:0]   num_active,
    input  logic             ld_en,
    input  logic [IDX_W-1:0] ld_idx,
    input  logic [WIDTH-1:0] ld_p_x,
    input  logic [WIDTH-1:0] ld_p_y,
    input  logic [WIDTH-1:0] ld_v_x,
    input  logic [WIDTH-1:0] ld_v_y,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_p_x,
    output logic [WIDTH-1:0] rd_p_y,
    output logic [WIDTH-1:0] rd_v_x,
    output logic [WIDTH-1:0] rd_v_y,
    output logic             calc_start,
    output logic [WIDTH-1:0] calc_p_x,
    output logic [WIDTH-1:0] calc_p_y,
    output logic [WIDTH-1:0] calc_v_x,
    output logic [WIDTH-1:0] calc_v_y,
    input  logic             calc_done,
    input  logic [WIDTH-1:0] calc_p_x_next,
    input  logic [WIDTH-1:0] calc_p_y_next,
    input  logic [WIDTH-1:0] calc_v_x_next,
    input  logic [WIDTH-1:0] calc_v_y_next,
    output logic             busy,
    output logic             frame_done,
    output logic             all_stopped,
    output logic             timeout_err
);

    localparam int              CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [IDX_W:0]  NB    = (IDX_W+1)'(NUM_BALLS);

    // Parameter sanity: index must cover the file, fraction must fit the word.
    if ((2**IDX_W) < NUM_BALLS || FRAC_WIDTH >= WIDTH || TIMEOUT < 1) begin : g_bad_params
        $error("ball_step_sequencer: inconsistent parameters");
    end

    typedef struct packed {
        logic [WIDTH-1:0] p_x;
        logic [WIDTH-1:0] p_y;
        logic [WIDTH-1:0] v_x;
        logic [WIDTH-1:0] v_y;
    } ball_t;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_SKIP, S_FINISH
    } state_t;

    state_t           state;
    ball_t            rf [NUM_BALLS];
    ball_t            rd_q, calc_q, res_q;
    logic [IDX_W-1:0] idx, last_idx, issue_idx;
    logic [IDX_W:0]   n_clamp;
    logic [CNT_W-1:0] wait_cnt;
    logic             scan, moving, ld_ok, rd_ok;

    assign {rd_p_x, rd_p_y, rd_v_x, rd_v_y}         = rd_q;
    assign {calc_p_x, calc_p_y, calc_v_x, calc_v_y} = calc_q;

    // Next ball to issue, clamped ball count, range checks, and whether the
    // ball being retired this cycle is still moving.
    always_comb begin
        issue_idx = (state == S_IDLE) ? '0 : idx + 1'b1;
        n_clamp   = (num_active > NB) ? NB : num_active;
        ld_ok     = ld_en && ({1'b0, ld_idx} < NB);
        rd_ok     = {1'b0, rd_idx} < NB;
        moving    = 1'b0;
        if (state == S_WRITE)
            moving = (res_q.v_x != '0) || (res_q.v_y != '0);
        else if (state == S_SKIP)
            moving = (rf[idx].v_x != '0) || (rf[idx].v_y != '0);
    end

    // Registered read port; sees the pre-write value during a WRITE cycle.
    always_ff @(posedge clk) begin
        if (!rst) rd_q <= '0;
        else      rd_q <= rd_ok ? rf[rd_idx] : '0;
    end

    // Frame sequencer: issue, wait for done (bounded), write back or skip.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            last_idx    <= '0;
            wait_cnt    <= '0;
            res_q       <= '0;
            calc_q      <= '0;
            scan        <= 1'b1;
            calc_start  <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            all_stopped <= 1'b1;
            timeout_err <= 1'b0;
            for (int i = 0; i < NUM_BALLS; i++) rf[i] <= '0;
        end else begin
            calc_start <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A load in the same cycle wins over start.
                    if (ld_en) begin
                        if (ld_ok) rf[ld_idx] <= {ld_p_x, ld_p_y, ld_v_x, ld_v_y};
                    end else if (start) begin
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                        scan        <= 1'b1;
                        if (n_clamp == '0) begin
                            state       <= S_FINISH;
                            frame_done  <= 1'b1;
                            all_stopped <= 1'b1;
                        end else begin
                            last_idx   <= IDX_W'(n_clamp - 1'b1);
                            idx        <= '0;
                            calc_q     <= rf[issue_idx];
                            calc_start <= 1'b1;
                            state      <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // Any done seen here belongs to the previous ball.
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (calc_done) begin
                        res_q <= {calc_p_x_next, calc_p_y_next, calc_v_x_next, calc_v_y_next};
                        state <= S_WRITE;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state <= S_SKIP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WRITE, S_SKIP: begin
                    if (state == S_WRITE) rf[idx] <= res_q;
                    else                  timeout_err <= 1'b1;
                    if (moving) scan <= 1'b0;
                    if (idx == last_idx) begin
                        state       <= S_FINISH;
                        frame_done  <= 1'b1;
                        all_stopped <= scan && !moving;
                    end else begin
                        idx        <= issue_idx;
                        calc_q     <= rf[issue_idx];
                        calc_start <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_step_sequencer.sv
// Randomized self-checking bench for ball_step_sequencer. A behavioural
// model holds the register file as plain 128-bit words and retires each
// frame in one step; a responder process plays the step unit.
module tb_ball_step_sequencer;

    localparam int W = 32;
    localparam int NB = 16;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [IW:0]   num_active = '0;
    logic          ld_en = 1'b0;
    logic [IW-1:0] ld_idx = '0;
    logic [W-1:0]  ld_p_x = '0, ld_p_y = '0, ld_v_x = '0, ld_v_y = '0;
    logic [IW-1:0] rd_idx = '0;
    logic [W-1:0]  rd_p_x, rd_p_y, rd_v_x, rd_v_y;
    logic          calc_start;
    logic [W-1:0]  calc_p_x, calc_p_y, calc_v_x, calc_v_y;
    logic          calc_done = 1'b0;
    logic [W-1:0]  calc_p_x_next = '0, calc_p_y_next = '0, calc_v_x_next = '0, calc_v_y_next = '0;
    logic          busy, frame_done, all_stopped, timeout_err;

    ball_step_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .num_active(num_active),
        .ld_en(ld_en), .ld_idx(ld_idx),
        .ld_p_x(ld_p_x), .ld_p_y(ld_p_y), .ld_v_x(ld_v_x), .ld_v_y(ld_v_y),
        .rd_idx(rd_idx),
        .rd_p_x(rd_p_x), .rd_p_y(rd_p_y), .rd_v_x(rd_v_x), .rd_v_y(rd_v_y),
        .calc_start(calc_start),
        .calc_p_x(calc_p_x), .calc_p_y(calc_p_y), .calc_v_x(calc_v_x), .calc_v_y(calc_v_y),
        .calc_done(calc_done),
        .calc_p_x_next(calc_p_x_next), .calc_p_y_next(calc_p_y_next),
        .calc_v_x_next(calc_v_x_next), .calc_v_y_next(calc_v_y_next),
        .busy(busy), .frame_done(frame_done), .all_stopped(all_stopped),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    wire [127:0] rd_all   = {rd_p_x, rd_p_y, rd_v_x, rd_v_y};
    wire [127:0] calc_all = {calc_p_x, calc_p_y, calc_v_x, calc_v_y};

    // model state and per-ball step-unit script for the current frame
    logic [127:0] m_rf   [NB];
    logic [127:0] exp_op [NB];
    logic [127:0] nxt    [NB];
    int           dly    [NB];   // 0 = never answers; 1..64 answered in time
    bit           stale  [NB];   // spurious done during the ISSUE cycle
    bit           m_stopped = 1'b1;
    int           issue_cnt = 0;
    int           n_vec = 0, n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // step-unit responder
    initial begin
        int cnt = 0;
        int cur = 0;
        forever begin
            @(negedge clk);
            calc_done = 1'b0;
            if (!rst || frame_done) begin
                cnt = 0;
            end else if (calc_start) begin
                cur = issue_cnt & (NB - 1);
                chk("calc_operands", calc_all, exp_op[cur]);
                issue_cnt++;
                cnt = dly[cur];
                if (stale[cur]) begin
                    calc_done = 1'b1;
                    {calc_p_x_next, calc_p_y_next, calc_v_x_next, calc_v_y_next} =
                        {32'hBAD0_0000 + cur, 32'h1, 32'h2, 32'h3};
                end
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    calc_done = 1'b1;
                    {calc_p_x_next, calc_p_y_next, calc_v_x_next, calc_v_y_next} = nxt[cur];
                end
            end
        end
    end

    task automatic load(input int i, input logic [127:0] val);
        @(negedge clk);
        ld_en = 1'b1;
        ld_idx = IW'(i);
        {ld_p_x, ld_p_y, ld_v_x, ld_v_y} = val;
        @(negedge clk);
        ld_en = 1'b0;
        m_rf[i] = val;
    endtask

    task automatic readall(input string tag);
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            rd_idx = IW'(i);
            @(negedge clk);
            chk(tag, rd_all, m_rf[i]);
        end
    endtask

    function automatic logic [127:0] rnd_ball(input bit vzero);
        logic [127:0] b;
        b = {$urandom, $urandom, $urandom, $urandom};
        if (vzero) b[63:0] = '0;
        return b;
    endfunction

    // Run one frame with the script in dly/nxt/stale; poke = try a start and
    // a load while busy. Model retires the whole frame afterwards.
    task automatic run_frame(input int na, input bit poke);
        int  n, exp_lat, lat, busy_low, ridx;
        bit  armed, exp_terr, stop;
        n = (na > NB) ? NB : na;
        exp_lat = 1;
        for (int i = 0; i < n; i++)
            exp_lat += 2 + ((dly[i] >= 1 && dly[i] <= 64) ? dly[i] : 64);
        for (int i = 0; i < NB; i++) exp_op[i] = m_rf[i];
        issue_cnt = 0;
        busy_low = 0;
        armed = 1'b0;
        ridx = 0;
        @(negedge clk);
        start = 1'b1;
        num_active = (IW+1)'(na);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!frame_done && lat < 3000) begin
            if (!busy) busy_low++;
            if (armed) chk("rd_mid_frame", rd_all, m_rf[ridx]);
            armed = 1'b0;
            if (n < NB) begin
                ridx = $urandom_range(n, NB - 1);
                rd_idx = IW'(ridx);
                armed = 1'b1;
            end
            if (poke && lat == 3) begin
                start = 1'b1;
                num_active = 1;
                ld_en = 1'b1;
                ld_idx = '0;
                {ld_p_x, ld_p_y, ld_v_x, ld_v_y} = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                start = 1'b0;
                ld_en = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        ld_en = 1'b0;
        chk("frame_latency", lat, exp_lat);
        chk("busy_in_frame", busy_low, 0);
        chk("busy_at_finish", busy, 1);
        chk("calc_start_count", issue_cnt, n);
        // model: balls answered in time are replaced, others keep their state
        exp_terr = 1'b0;
        stop = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (dly[i] >= 1 && dly[i] <= 64) m_rf[i] = nxt[i];
            else exp_terr = 1'b1;
            if (m_rf[i][63:0] != '0) stop = 1'b0;
        end
        m_stopped = stop;
        @(negedge clk);
        chk("busy_after", busy, 0);
        chk("frame_done_pulse", frame_done, 0);
        chk("all_stopped", all_stopped, m_stopped);
        chk("timeout_err", timeout_err, exp_terr);
        readall("regfile");
    endtask

    task automatic script_fast(input bit vzero);
        for (int i = 0; i < NB; i++) begin
            dly[i] = 1;
            stale[i] = 1'b0;
            nxt[i] = rnd_ball(vzero);
        end
    endtask

    initial begin
        int na;
        for (int i = 0; i < NB; i++) m_rf[i] = '0;
        // reset
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_stopped", all_stopped, 1);
        chk("rst_calc", {calc_start, calc_all}, 0);
        rst = 1'b1;
        readall("rst_regfile");

        // single ball, answer two cycles after calc_start
        load(0, {32'h4000_0000, 32'h0, 32'h1000_0000, 32'h0});
        script_fast(1'b0);
        dly[0] = 2;
        nxt[0] = {32'h43E0_0000, 32'h0, 32'h0F00_0000, 32'h0};
        run_frame(1, 1'b0);

        // three balls stop; stale done in ISSUE must be ignored
        for (int i = 0; i < 3; i++) load(i, rnd_ball(1'b0));
        script_fast(1'b1);
        stale[1] = 1'b1;
        run_frame(3, 1'b0);

        // step unit never answers: both balls skipped
        script_fast(1'b0);
        dly[0] = 0;
        dly[1] = 0;
        run_frame(2, 1'b0);

        // start and load while busy are ignored; timeout_err clears
        script_fast(1'b0);
        run_frame(3, 1'b1);

        // boundary: done on the last allowed WAIT cycle vs one cycle late
        script_fast(1'b0);
        dly[0] = 64;
        dly[1] = 65;
        run_frame(2, 1'b0);

        // empty frame
        script_fast(1'b0);
        run_frame(0, 1'b0);

        // load and start together: load only, no frame
        issue_cnt = 0;
        @(negedge clk);
        ld_en = 1'b1;
        ld_idx = 4'd5;
        {ld_p_x, ld_p_y, ld_v_x, ld_v_y} = {32'h1, 32'h2, 32'h3, 32'h4};
        start = 1'b1;
        num_active = 5'd2;
        m_rf[5] = {32'h1, 32'h2, 32'h3, 32'h4};
        @(negedge clk);
        ld_en = 1'b0;
        start = 1'b0;
        begin
            int b = 0;
            for (int c = 0; c < 5; c++) begin
                if (busy || frame_done) b++;
                @(negedge clk);
            end
            chk("ld_start_no_frame", b + issue_cnt, 0);
        end
        readall("ld_start_regfile");

        // randomized frames, including num_active above NUM_BALLS
        for (int f = 0; f < 14; f++) begin
            for (int j = 0; j < 3; j++) load($urandom_range(0, NB - 1), rnd_ball($urandom_range(0, 2) == 0));
            for (int i = 0; i < NB; i++) begin
                int r = $urandom_range(0, 19);
                dly[i] = (r == 0) ? 0 : (r == 1) ? 64 : (r == 2) ? 65 : $urandom_range(1, 4);
                stale[i] = ($urandom_range(0, 3) == 0);
                nxt[i] = rnd_ball($urandom_range(0, 1) == 0);
            end
            na = $urandom_range(0, 20);
            run_frame(na, (f % 4) == 1);
        end

        // reset during WAIT of ball 1 of 4
        script_fast(1'b0);
        dly[1] = 0;
        for (int i = 0; i < NB; i++) exp_op[i] = m_rf[i];
        issue_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        num_active = 5'd4;
        @(negedge clk);
        start = 1'b0;
        begin
            int c = 0;
            while (issue_cnt < 2 && c < 100) begin
                @(negedge clk);
                c++;
            end
            chk("reach_ball1", issue_cnt >= 2, 1);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_stopped", all_stopped, 1);
        chk("rst_mid_flags", {frame_done, timeout_err, calc_start}, 0);
        chk("rst_mid_outs", {rd_all, calc_all}, 0);
        rst = 1'b1;
        for (int i = 0; i < NB; i++) m_rf[i] = '0;
        m_stopped = 1'b1;
        readall("rst_mid_regfile");
        load(2, rnd_ball(1'b0));
        script_fast(1'b0);
        run_frame(3, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

endmodule
